// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Serialises Y86-64 SEQ writeback and decode accesses onto a
//               single-port 15 x WIDTH register file.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RSP   = 4'h4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wb_en,
  input  logic [3:0]       wb_icode,
  input  logic [3:0]       wb_rA,
  input  logic [3:0]       wb_rB,
  input  logic             wb_Cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic             rd_en,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       rf_addr,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_rdata
);

  // Encoding order matches access order; next_from relies on it.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR_E = 3'd1;
  localparam logic [2:0] S_WR_M = 3'd2;
  localparam logic [2:0] S_RD_A = 3'd3;
  localparam logic [2:0] S_RD_B = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       r_state;
  logic [3:0]       r_dste, r_dstm, r_srca, r_srcb;
  logic [WIDTH-1:0] r_vale, r_valm, r_vala, r_valb;
  logic             r_err;

  logic [3:0]       w_srca, w_srcb, w_dste, w_dstm;
  logic             w_err;

  always_comb begin
    w_srca = RNONE;
    w_srcb = RNONE;
    w_dste = RNONE;
    w_dstm = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: w_srca = rA;
      4'h9, 4'hB:             w_srca = RSP;
      default:                w_srca = RNONE;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       w_srcb = rB;
      4'h8, 4'h9, 4'hA, 4'hB: w_srcb = RSP;
      default:                w_srcb = RNONE;
    endcase
    case (wb_icode)
      4'h3, 4'h6:             w_dste = wb_rB;
      4'h2:                   w_dste = wb_Cnd ? wb_rB : RNONE;
      4'h8, 4'h9, 4'hA, 4'hB: w_dste = RSP;
      default:                w_dste = RNONE;
    endcase
    case (wb_icode)
      4'h5, 4'hB:             w_dstm = wb_rA;
      default:                w_dstm = RNONE;
    endcase
    if (!rd_en) begin
      w_srca = RNONE;
      w_srcb = RNONE;
    end
    if (!wb_en) begin
      w_dste = RNONE;
      w_dstm = RNONE;
    end
    w_err = (wb_en && (wb_icode > 4'hB)) || (rd_en && (icode > 4'hB));
  end

  // First state after 'from' whose register is needed; RNONE accesses cost no cycle.
  function automatic logic [2:0] next_from(input logic [2:0] from,
                                           input logic [3:0] dste, input logic [3:0] dstm,
                                           input logic [3:0] srca, input logic [3:0] srcb);
    if ((from == S_IDLE) && (dste != RNONE)) return S_WR_E;
    if ((from <= S_WR_E) && (dstm != RNONE)) return S_WR_M;
    if ((from <= S_WR_M) && (srca != RNONE)) return S_RD_A;
    if ((from <= S_RD_A) && (srcb != RNONE)) return S_RD_B;
    return S_DONE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dste  <= RNONE;
      r_dstm  <= RNONE;
      r_srca  <= RNONE;
      r_srcb  <= RNONE;
      r_vale  <= '0;
      r_valm  <= '0;
      r_vala  <= '0;
      r_valb  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dste  <= w_dste;
            r_dstm  <= w_dstm;
            r_srca  <= w_srca;
            r_srcb  <= w_srcb;
            r_vale  <= valE;
            r_valm  <= valM;
            r_vala  <= '0;
            r_valb  <= '0;
            r_err   <= w_err;
            r_state <= w_err ? S_DONE : next_from(S_IDLE, w_dste, w_dstm, w_srca, w_srcb);
          end
        end
        S_WR_E, S_WR_M: begin
          r_state <= next_from(r_state, r_dste, r_dstm, r_srca, r_srcb);
        end
        S_RD_A: begin
          r_vala  <= rf_rdata;
          r_state <= next_from(r_state, r_dste, r_dstm, r_srca, r_srcb);
        end
        S_RD_B: begin
          r_valb  <= rf_rdata;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state, so the async reset removes rf_we immediately.
  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = RNONE;
    rf_wdata = '0;
    case (r_state)
      S_WR_E: begin
        rf_we    = 1'b1;
        rf_addr  = r_dste;
        rf_wdata = r_vale;
      end
      S_WR_M: begin
        rf_we    = 1'b1;
        rf_addr  = r_dstm;
        rf_wdata = r_valm;
      end
      S_RD_A:  rf_addr = r_srca;
      S_RD_B:  rf_addr = r_srcb;
      default: rf_addr = RNONE;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = r_err;
  assign valA = r_vala;
  assign valB = r_valb;

endmodule
`default_nettype wire
